// File: rtl/mm_stage_ctrl.sv
// mm_stage_ctrl: memory-stage controller sequencing data-memory requests, pipeline
// enable/squash and the halt/flush handshake. Define MM_STALL_CNT_EN to build the
// data-memory wait-cycle counter; otherwise stall_cnt is tied to zero.
module mm_stage_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dRENi,
    input  logic        dWENi,
    input  logic        halt,
    input  logic        taken,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        flushed,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        pipe_en,
    output logic        squash,
    output logic        dcache_flush,
    output logic        halted,
    output logic [31:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE, MEMREQ, HALTING, HALTED} state_t;
    state_t state, next;

    // state register, asynchronously forced to IDLE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    // next state and Mealy outputs; everything held low while RST is asserted
    always_comb begin
        next         = state;
        dmemREN      = 1'b0;
        dmemWEN      = 1'b0;
        pipe_en      = 1'b0;
        dcache_flush = 1'b0;
        halted       = 1'b0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    pipe_en = ihit & ~halt & ~(dRENi | dWENi);
                    next    = halt ? HALTING : (dRENi | dWENi) ? MEMREQ : IDLE;
                end
                MEMREQ: begin
                    dmemWEN = dWENi;
                    dmemREN = dRENi & ~dWENi;
                    pipe_en = dhit;
                    next    = dhit ? IDLE : MEMREQ;
                end
                HALTING: begin
                    dcache_flush = 1'b1;
                    next         = flushed ? HALTED : HALTING;
                end
                HALTED: halted = 1'b1;
            endcase
        end
        squash = taken & pipe_en;
    end

`ifdef MM_STALL_CNT_EN
    logic [31:0] cnt;

    // saturating count of MEMREQ cycles still waiting on dhit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                                   cnt <= '0;
        else if (state == MEMREQ && !dhit && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_mm_stage_ctrl.sv
// tb_mm_stage_ctrl: scoreboard bench for mm_stage_ctrl, directed scenarios plus random traffic.
module tb_mm_stage_ctrl;
    logic CLK = 1'b0, RST = 1'b1;
    logic dRENi = 0, dWENi = 0, halt = 0, taken = 0, ihit = 0, dhit = 0, flushed = 0;
    logic dmemREN, dmemWEN, pipe_en, squash, dcache_flush, halted;
    logic [31:0] stall_cnt;

    mm_stage_ctrl dut (
        .CLK(CLK), .RST(RST), .dRENi(dRENi), .dWENi(dWENi), .halt(halt), .taken(taken),
        .ihit(ihit), .dhit(dhit), .flushed(flushed), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pipe_en(pipe_en), .squash(squash), .dcache_flush(dcache_flush), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  o;
        logic [31:0] c;
    } exp_t;
    exp_t q[$];
    int checks = 0, fails = 0;

    // reference: what the MM stage is doing, as plain flags
    bit busy, flushing, stopped;
    longint waits;

    task automatic model_reset();
        busy = 0; flushing = 0; stopped = 0; waits = 0;
    endtask

    task automatic model_edge();
        if (RST) begin
            model_reset();
        end else if (stopped) begin
        end else if (flushing) begin
            if (flushed) begin flushing = 0; stopped = 1; end
        end else if (busy) begin
`ifdef MM_STALL_CNT_EN
            if (!dhit && waits < 64'hFFFF_FFFF) waits++;
`endif
            if (dhit) busy = 0;
        end else if (halt) begin
            flushing = 1;
        end else if (dRENi || dWENi) begin
            busy = 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit ren = 0, wen = 0, pe = 0, fl = 0, hd = 0;
        if (!RST) begin
            if (stopped) hd = 1;
            else if (flushing) fl = 1;
            else if (busy) begin
                wen = dWENi;
                ren = dRENi && !dWENi;
                pe  = dhit;
            end else pe = ihit && !halt && !dRENi && !dWENi;
        end
        e.o = {ren, wen, pe, taken && pe, fl, hd};
        e.c = RST ? 32'd0 : waits[31:0];
        return e;
    endfunction

    task automatic cyc(input logic r, dr, dw, h, t, ih, dh, fl);
        @(posedge CLK);
        #1;
        model_edge();
        RST = r; dRENi = dr; dWENi = dw; halt = h; taken = t; ihit = ih; dhit = dh; flushed = fl;
        if (r) model_reset();
        #1;
        q.push_back(model_out());
    endtask

    // monitor: outputs are combinational and settled by the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({dmemREN, dmemWEN, pipe_en, squash, dcache_flush, halted} !== e.o) begin
                    fails++;
                    $display("FAIL outputs t=%0t ren/wen/pe/sq/fl/hd got %b exp %b", $time,
                             {dmemREN, dmemWEN, pipe_en, squash, dcache_flush, halted}, e.o);
                end
                checks++;
                if (stall_cnt !== e.c) begin
                    fails++;
                    $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.c);
                end
            end
        end
    end

    initial begin
        model_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // load with three wait cycles then dhit
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // read and write together: write wins
        cyc(0, 1, 1, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 1, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 1, 0);
        // store then load back to back
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 1, 0);
        // squash follows pipe_en
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 1, 0);
        // reset in the middle of a load after five waits
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // halt beats a pending load; flush completes in the fourth flush cycle
        cyc(0, 1, 0, 1, 0, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 1, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 1, 0, 1);
        repeat (4) cyc(0, 1, 1, 1, 1, 1, 1, 1);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(99) < 2, $urandom_range(99) < 40, $urandom_range(99) < 30,
                $urandom_range(99) < 3, $urandom_range(1), $urandom_range(99) < 70,
                $urandom_range(99) < 40, $urandom_range(99) < 30);
        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
